dshot_rx_bank: RTL and testbench
================================

Name: dshot_rx_bank

Overview:
Eight-channel DShot600 frame receiver that decodes flight-controller DShot lines into 8-bit motor target speeds. It sits directly upstream of the I2C BL-Ctrl handler and drives that handler's 64-bit packed target-speed bus and its per-motor enables. Each channel checks pulse timing and CRC, maps the throttle value to 0..255, and forces the speed to 0 when the link goes silent.

Parameters:
NUM_CH, 8, number of channels; speed_flat width is 8*NUM_CH
BIT_THRESH, 15, high-time threshold in clk cycles; a high time at or above it is a 1, otherwise a 0 (16 MHz clk, DShot600)
MIN_HIGH, 5, shortest legal high pulse in cycles
MAX_HIGH, 25, longest legal high pulse in cycles
GAP_CYCLES, 40, low time in cycles at or above which a frame boundary is declared
TIMEOUT_CYCLES, 800000, cycles without a valid frame before failsafe (50 ms)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
dshot_in  in  NUM_CH  raw DShot lines, asynchronous; bit i is channel i
speed_flat  out  8*NUM_CH  channel i speed at [8*NUM_CH-1-8i -: 8]; channel 0 in the MSB byte
channel_alive  out  NUM_CH  1 = a valid frame was received within TIMEOUT_CYCLES
frame_strobe  out  NUM_CH  1-cycle pulse per accepted frame
crc_error  out  NUM_CH  1-cycle pulse per complete frame that fails CRC

Behaviour:
- Reset: speed_flat=0, channel_alive=0, frame_strobe=0, crc_error=0, every channel in WAIT_GAP with all counters at 0.
- Each input passes through a 2-flop synchronizer. Edge detection uses the second stage and the previous value.
- Per-channel FSM:
  - WAIT_GAP: the low counter increments while the line is low and clears while it is high. When low_cnt >= GAP_CYCLES, go to RECV with bit_idx=0.
  - RECV: high_cnt counts cycles while the line is high and saturates at MAX_HIGH+1.
    - If high_cnt > MAX_HIGH while still high: abort to WAIT_GAP.
    - On a falling edge with high_cnt < MIN_HIGH: abort to WAIT_GAP.
    - Otherwise shift bit (high_cnt >= BIT_THRESH) into a 16-bit register, MSB first, and increment bit_idx.
    - After the 16th bit, go to CHECK.
    - A low time >= GAP_CYCLES with bit_idx in 1..15 is a truncated frame: discard it, reset bit_idx=0, and stay in RECV (the gap has already been seen). No error pulse.
  - CHECK (1 cycle): v = frame[15:4]; crc = (v ^ v>>4 ^ v>>8) & 4'hF.
    - If crc == frame[3:0], the frame is valid; otherwise pulse crc_error.
    - Always go to WAIT_GAP with low_cnt=0, so extra bits before the next gap are ignored.
- Speed mapping for valid frames, using throttle t = frame[15:5]; frame[4] (telemetry) is ignored:
  - t=0: speed 0.
  - t in 1..47: special command; speed is unchanged, but the frame still counts as valid for strobe and timeout.
  - t in 48..2047: speed = ((t-48)*131)>>10. Use a 19-bit product. The result spans 0..255 and needs no saturation.
- Latency: the output register updates speed and pulses frame_strobe exactly 4 clk rising edges after the final falling edge is sampled by the first sync flop. crc_error uses the same latency.
- Failsafe: a per-channel counter clears on each valid frame and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: channel_alive=0 and speed=0 in the same cycle.
  - The first valid frame after that sets channel_alive=1 together with frame_strobe.
- Channels are fully independent. Simultaneous events on different channels need no arbitration.
- An async reset mid-frame discards the frame. The channel must see a full gap before accepting data.

Decomposition:
- Package dshot_pkg holds:
  - the state encoding (WAIT_GAP, RECV, CHECK);
  - the frame field positions;
  - the THROTTLE_MIN=48 and SCALE_MUL=131 constants;
  - a crc4 function.
- Sub-module dshot_rx_channel contains the synchronizer, FSM, CRC, mapping and timeout, with outputs speed[7:0], alive, strobe and crc_err.
- The top level only generates NUM_CH instances and packs speed_flat.

Test Plan:
- Gap, then frame 0x82E4 (t=1047) on ch0 -> crc_error=0; frame_strobe[0] pulses 4 cycles after the last falling edge; speed_flat[63:56]=0x7F; channel_alive[0]=1.
- Frame 0xFFEE (t=2047) on ch7 -> speed_flat[7:0]=0xFF. Frame 0x0606 (t=48) -> 0x00. Frame 0x0000 -> 0x00.
- Frame 0x82E5 after a valid 0x7F on ch0 -> crc_error[0] pulses once; no strobe; speed stays 0x7F.
- Stimulus pulses: one 3-cycle high pulse; separately, one 30-cycle high pulse; separately, only 10 bits followed by a gap -> no strobe and no crc_error; the next clean frame decodes normally.
- After a valid frame, no further input for 800000 cycles -> channel_alive=0 and that byte=0 at the expiry cycle. The next valid frame restores alive and the new speed.
- Different valid frames on all 8 channels with overlapping timing -> each byte is correct. Assert rst mid-frame -> all outputs 0; a frame starting without a preceding gap is ignored.

Source files
------------

// File: rtl/dshot_pkg.sv
// Shared constants for the DShot600 receiver bank: state encoding, frame layout,
// throttle scaling and the 4-bit frame checksum.
package dshot_pkg;

    localparam logic [1:0] WAIT_GAP = 2'd0;
    localparam logic [1:0] RECV     = 2'd1;
    localparam logic [1:0] CHECK    = 2'd2;

    localparam int FRAME_W  = 16;
    localparam int THR_MSB  = 15;
    localparam int THR_LSB  = 5;
    localparam int TLM_BIT  = 4;
    localparam int DATA_LSB = 4;
    localparam int CRC_MSB  = 3;

    localparam int THROTTLE_MIN = 48;
    localparam int SCALE_MUL    = 131;

    function automatic logic [3:0] crc4(input logic [11:0] v);
        logic [11:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[3:0];
    endfunction

endpackage

// File: rtl/dshot_rx_channel.sv
// One DShot600 line: synchronizer, pulse-timing FSM, checksum, throttle mapping and failsafe.
// state    | meaning
// WAIT_GAP | waiting for a low period long enough to mark a frame boundary
// RECV     | measuring high pulses and shifting in frame bits
// CHECK    | one cycle to validate the checksum and stage the result
module dshot_rx_channel
    import dshot_pkg::*;
#(
    parameter int BIT_THRESH     = 15,
    parameter int MIN_HIGH       = 5,
    parameter int MAX_HIGH       = 25,
    parameter int GAP_CYCLES     = 40,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] speed,
    output logic       alive,
    output logic       strobe,
    output logic       crc_err
);

    localparam int LW = $clog2(GAP_CYCLES + 1);
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] GAP_C   = LW'(GAP_CYCLES);
    localparam logic [HW-1:0] MINH    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] MAXH    = HW'(MAX_HIGH);
    localparam logic [HW-1:0] THR_C   = HW'(BIT_THRESH);
    localparam logic [HW-1:0] HSAT    = HW'(MAX_HIGH + 1);
    localparam logic [TW-1:0] TO_C    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic              sync1, sync2, prev;
    logic [1:0]        state;
    logic [LW-1:0]     low_cnt;
    logic [HW-1:0]     high_cnt;
    logic [3:0]        bit_idx;
    logic [FRAME_W-1:0] frame;
    logic              pend_strobe, pend_err, pend_load;
    logic [7:0]        pend_speed;
    logic [TW-1:0]     to_cnt;

    logic [10:0] thr, thr_off;
    logic [18:0] prod;
    logic [7:0]  mapped;
    logic        crc_ok;

    assign thr     = frame[THR_MSB:THR_LSB];
    assign thr_off = thr - 11'(THROTTLE_MIN);
    assign prod    = 19'(thr_off) * 19'(SCALE_MUL);
    assign mapped  = 8'(prod >> 10);
    assign crc_ok  = (crc4(frame[FRAME_W-1:DATA_LSB]) == frame[CRC_MSB:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            prev        <= 1'b0;
            state       <= WAIT_GAP;
            low_cnt     <= '0;
            high_cnt    <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            pend_strobe <= 1'b0;
            pend_err    <= 1'b0;
            pend_load   <= 1'b0;
            pend_speed  <= '0;
        end else begin
            sync1       <= din;
            sync2       <= sync1;
            prev        <= sync2;
            pend_strobe <= 1'b0;
            pend_err    <= 1'b0;
            pend_load   <= 1'b0;
            case (state)
                WAIT_GAP: begin
                    if (low_cnt >= GAP_C) begin
                        state    <= RECV;
                        bit_idx  <= '0;
                        high_cnt <= '0;
                    end else if (sync2) begin
                        low_cnt <= '0;
                    end else begin
                        low_cnt <= low_cnt + LW'(1);
                    end
                end
                RECV: begin
                    if (sync2) begin
                        low_cnt <= '0;
                        if (high_cnt > MAXH) begin
                            state    <= WAIT_GAP;
                            high_cnt <= '0;
                            bit_idx  <= '0;
                        end else if (high_cnt != HSAT) begin
                            high_cnt <= high_cnt + HW'(1);
                        end
                    end else begin
                        if (low_cnt != GAP_C) low_cnt <= low_cnt + LW'(1);
                        if (prev) begin
                            high_cnt <= '0;
                            if (high_cnt < MINH) begin
                                state   <= WAIT_GAP;
                                bit_idx <= '0;
                                low_cnt <= '0;
                            end else begin
                                frame   <= {frame[FRAME_W-2:0], (high_cnt >= THR_C)};
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == 4'd15) state <= CHECK;
                            end
                        end else if (low_cnt >= GAP_C) begin
                            // truncated frame: drop partial bits, the gap is already seen
                            bit_idx <= '0;
                        end
                    end
                end
                CHECK: begin
                    state    <= WAIT_GAP;
                    low_cnt  <= '0;
                    high_cnt <= '0;
                    bit_idx  <= '0;
                    if (crc_ok) begin
                        pend_strobe <= 1'b1;
                        pend_load   <= (thr == 11'd0) || (thr >= 11'(THROTTLE_MIN));
                        pend_speed  <= (thr == 11'd0) ? 8'd0 : mapped;
                    end else begin
                        pend_err <= 1'b1;
                    end
                end
                default: state <= WAIT_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed   <= '0;
            alive   <= 1'b0;
            strobe  <= 1'b0;
            crc_err <= 1'b0;
            to_cnt  <= '0;
        end else begin
            strobe  <= pend_strobe;
            crc_err <= pend_err;
            if (pend_strobe) begin
                alive  <= 1'b1;
                to_cnt <= '0;
                if (pend_load) speed <= pend_speed;
            end else if (to_cnt != TO_C) begin
                to_cnt <= to_cnt + TW'(1);
                if (to_cnt == TO_LAST) begin
                    alive <= 1'b0;
                    speed <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/dshot_rx_bank.sv
// Bank of independent DShot600 receivers feeding the BL-Ctrl packed target-speed bus;
// channel 0 occupies the most significant byte of speed_flat.
module dshot_rx_bank
    import dshot_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int BIT_THRESH     = 15,
    parameter int MIN_HIGH       = 5,
    parameter int MAX_HIGH       = 25,
    parameter int GAP_CYCLES     = 40,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     dshot_in,
    output logic [8*NUM_CH-1:0]   speed_flat,
    output logic [NUM_CH-1:0]     channel_alive,
    output logic [NUM_CH-1:0]     frame_strobe,
    output logic [NUM_CH-1:0]     crc_error
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dshot_rx_channel #(
            .BIT_THRESH     (BIT_THRESH),
            .MIN_HIGH       (MIN_HIGH),
            .MAX_HIGH       (MAX_HIGH),
            .GAP_CYCLES     (GAP_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .din     (dshot_in[i]),
            .speed   (speed_flat[8*NUM_CH-1-8*i -: 8]),
            .alive   (channel_alive[i]),
            .strobe  (frame_strobe[i]),
            .crc_err (crc_error[i])
        );
    end

endmodule

// File: tb/tb_dshot_rx_bank.sv
// Scoreboard bench for dshot_rx_bank: frames are bit-banged per channel, expected
// events are queued at the final falling edge and matched by a negedge monitor.
module tb_dshot_rx_bank;

    localparam int NUM_CH = 8;
    localparam int TO     = 3000;
    localparam int GAP    = 60;
    localparam int ONE_H  = 20, ONE_L  = 6;
    localparam int ZERO_H = 8,  ZERO_L = 18;

    typedef struct {
        int         ch;
        bit         is_err;
        logic [7:0] speed;
        int         cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    din = '0;
    logic [8*NUM_CH-1:0]  speed_flat;
    logic [NUM_CH-1:0]    channel_alive, frame_strobe, crc_error;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt;
    int   last_strobe [NUM_CH];
    logic [7:0] cur [NUM_CH];
    exp_t sb[$];

    dshot_rx_bank #(
        .NUM_CH         (NUM_CH),
        .BIT_THRESH     (15),
        .MIN_HIGH       (5),
        .MAX_HIGH       (25),
        .GAP_CYCLES     (40),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dshot_in      (din),
        .speed_flat    (speed_flat),
        .channel_alive (channel_alive),
        .frame_strobe  (frame_strobe),
        .crc_error     (crc_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_of(input int c);
        return speed_flat[8*NUM_CH-1-8*c -: 8];
    endfunction

    function automatic logic [15:0] mk(input int t, input bit tlm);
        logic [11:0] v, x;
        v = {11'(t), tlm};
        x = v ^ (v >> 4) ^ (v >> 8);
        return {v, x[3:0]};
    endfunction

    function automatic logic [7:0] map_t(input int t, input logic [7:0] prev_sp);
        if (t == 0) return 8'd0;
        if (t < 48) return prev_sp;
        return 8'(((t - 48) * 131) >> 10);
    endfunction

    // kind: 0 = no event expected, 1 = strobe, 2 = crc error
    task automatic send_frame(input int ch, input logic [15:0] w, input bit gap,
                              input int nbits, input int kind, input logic [7:0] sp);
        exp_t e;
        if (gap) begin
            din[ch] = 1'b0;
            repeat (GAP) @(negedge clk);
        end
        for (int b = 15; b > 15 - nbits; b--) begin
            din[ch] = 1'b1;
            repeat (w[b] ? ONE_H : ZERO_H) @(negedge clk);
            din[ch] = 1'b0;
            if (b == 16 - nbits && kind != 0) begin
                e.ch = ch; e.is_err = (kind == 2); e.speed = sp; e.cyc = cyc + 5;
                sb.push_back(e);
            end
            repeat (w[b] ? ONE_L : ZERO_L) @(negedge clk);
        end
    endtask

    task automatic send_valid(input int ch, input int t);
        cur[ch] = map_t(t, cur[ch]);
        send_frame(ch, mk(t, 1'b0), 1'b1, 16, 1, cur[ch]);
    endtask

    task automatic send_pulse(input int ch, input int hi);
        din[ch] = 1'b0;
        repeat (GAP) @(negedge clk);
        din[ch] = 1'b1;
        repeat (hi) @(negedge clk);
        din[ch] = 1'b0;
        repeat (ZERO_L) @(negedge clk);
    endtask

    task automatic wait_sb(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_events: outstanding=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (frame_strobe[c] || crc_error[c]) begin
                    int   idx;
                    exp_t e;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].ch == c) idx = k;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_event ch%0d: strobe=%b crc_error=%b cyc=%0d, required no event",
                                 c, frame_strobe[c], crc_error[c], cyc);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        if (cyc != e.cyc || frame_strobe[c] !== !e.is_err || crc_error[c] !== e.is_err ||
                            byte_of(c) !== e.speed || (!e.is_err && channel_alive[c] !== 1'b1)) begin
                            errors++;
                            $display("FAIL event ch%0d: cyc=%0d strobe=%b err=%b speed=%02h alive=%b, required cyc=%0d err=%b speed=%02h",
                                     c, cyc, frame_strobe[c], crc_error[c], byte_of(c), channel_alive[c],
                                     e.cyc, e.is_err, e.speed);
                        end
                    end
                    if (frame_strobe[c]) last_strobe[c] = cyc;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if (speed_flat !== '0 || channel_alive !== '0 || frame_strobe !== '0 || crc_error !== '0) begin
            errors++;
            $display("FAIL %s: speed_flat=%h alive=%b strobe=%b crc=%b, required all zero",
                     name, speed_flat, channel_alive, frame_strobe, crc_error);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_decode();
        cur[0] = 8'h7F;
        send_frame(0, 16'h82E4, 1'b1, 16, 1, 8'h7F);
        wait_sb("decode_ch0");
        checks++;
        if (channel_alive[0] !== 1'b1 || byte_of(0) !== 8'h7F || crc_error !== '0) begin
            errors++;
            $display("FAIL decode_ch0_hold: alive=%b speed=%02h crc=%b, required 1 7f 0",
                     channel_alive[0], byte_of(0), crc_error);
        end
        cur[7] = 8'hFF;
        send_frame(7, 16'hFFEE, 1'b1, 16, 1, 8'hFF);
        cur[7] = 8'h00;
        send_frame(7, 16'h0606, 1'b1, 16, 1, 8'h00);
        send_frame(7, 16'hFFEE, 1'b1, 16, 1, 8'hFF);
        send_frame(7, 16'h0000, 1'b1, 16, 1, 8'h00);
        wait_sb("decode_ch7");
        checks++;
        if (byte_of(7) !== 8'h00 || byte_of(0) !== 8'h7F) begin
            errors++;
            $display("FAIL decode_bytes: ch7=%02h ch0=%02h, required 00 7f", byte_of(7), byte_of(0));
        end
    endtask

    task automatic test_crc_and_command();
        send_valid(0, 1047);
        send_frame(0, 16'h82E5, 1'b1, 16, 2, cur[0]);
        send_valid(0, 5);
        wait_sb("crc_error");
        checks++;
        if (byte_of(0) !== 8'h7F) begin
            errors++;
            $display("FAIL crc_speed_kept: speed=%02h, required 7f", byte_of(0));
        end
    endtask

    task automatic test_bad_pulses();
        send_pulse(1, 3);
        send_frame(1, mk(700, 1'b0), 1'b0, 16, 0, 8'h00);
        send_valid(1, 700);
        send_pulse(1, 30);
        send_frame(1, mk(900, 1'b0), 1'b0, 16, 0, 8'h00);
        send_valid(1, 900);
        send_frame(1, mk(1200, 1'b0), 1'b1, 10, 0, 8'h00);
        send_valid(1, 1200);
        wait_sb("bad_pulses");
        checks++;
        if (byte_of(1) !== map_t(1200, 8'h00)) begin
            errors++;
            $display("FAIL bad_pulses_speed: speed=%02h, required %02h", byte_of(1), map_t(1200, 8'h00));
        end
    endtask

    task automatic test_timeout();
        int s, n;
        send_valid(0, 1047);
        wait_sb("timeout_arm");
        s = last_strobe[0];
        n = 0;
        while (cyc < s + TO - 1 && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != s + TO - 1 || channel_alive[0] !== 1'b1 || byte_of(0) !== 8'h7F) begin
            errors++;
            $display("FAIL timeout_before: cyc=%0d alive=%b speed=%02h, required cyc=%0d 1 7f",
                     cyc, channel_alive[0], byte_of(0), s + TO - 1);
        end
        @(negedge clk);
        checks++;
        if (channel_alive[0] !== 1'b0 || byte_of(0) !== 8'h00) begin
            errors++;
            $display("FAIL timeout_expiry: alive=%b speed=%02h, required 0 00", channel_alive[0], byte_of(0));
        end
        cur[0] = 8'h00;
        send_valid(0, 2047);
        wait_sb("timeout_recover");
        checks++;
        if (channel_alive[0] !== 1'b1 || byte_of(0) !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_recover_hold: alive=%b speed=%02h, required 1 ff", channel_alive[0], byte_of(0));
        end
    endtask

    task automatic test_all_channels();
        int tv [NUM_CH] = '{100, 500, 48, 2047, 1047, 0, 300, 1500};
        int n = 0;
        done_cnt = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            automatic int cc = c;
            fork
                begin
                    repeat (cc * 9) @(negedge clk);
                    send_valid(cc, tv[cc]);
                    done_cnt++;
                end
            join_none
        end
        while (done_cnt < NUM_CH && n < 3000) begin
            @(negedge clk);
            n++;
        end
        wait_sb("all_channels");
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (byte_of(c) !== map_t(tv[c], 8'h00) || channel_alive[c] !== 1'b1) begin
                errors++;
                $display("FAIL all_channels_byte ch%0d: speed=%02h alive=%b, required %02h 1",
                         c, byte_of(c), channel_alive[c], map_t(tv[c], 8'h00));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(2, mk(800, 1'b0), 1'b1, 8, 0, 8'h00);
        din[2] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_async");
        din[2] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_held");
        for (int c = 0; c < NUM_CH; c++) cur[c] = 8'h00;
        rst = 1'b0;
        send_frame(2, mk(800, 1'b0), 1'b0, 16, 0, 8'h00);
        repeat (10) @(negedge clk);
        checks++;
        if (channel_alive[2] !== 1'b0 || byte_of(2) !== 8'h00) begin
            errors++;
            $display("FAIL no_gap_ignored: alive=%b speed=%02h, required 0 00", channel_alive[2], byte_of(2));
        end
        send_valid(2, 800);
        wait_sb("after_reset");
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            cur[c] = 8'h00;
            last_strobe[c] = 0;
        end
        test_reset();
        test_decode();
        test_crc_and_command();
        test_bad_pulses();
        test_timeout();
        test_all_channels();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
